impact_sram_ctrl: RTL and testbench
===================================

Name: impact_sram_ctrl

Overview:
- Parametrised successor to the IMPACT SRAM head: a byte-serial GPIO command port drives NUM_BANKS SRAM macros of BYTES_PER_WORD-byte words.
- Adds features the original head lacked: strobe synchronisation and edge detection, a configurable read latency, per-byte write masks, read-data truncation for approximate-memory experiments, and busy/drop status.
- Sits between the user_project_wrapper GPIO pins and the SRAM macro instances.

Parameters:
- NUM_BANKS, 4, number of SRAM banks (2..8).
- WORD_ADDR_W, 10, word address width per bank.
- BYTES_PER_WORD, 4, bytes per SRAM word (power of 2, 1..8).
- RD_LATENCY, 1, clk cycles from macro read issue until sram_dout is valid (1..4).
- SYNC_STAGES, 2, flops in the strobe synchronisers (2..3).

Ports:
- clk  in  1  user project clock (GPIO 37).
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  8  write byte.
- data_out  out  8  registered read byte.
- word_sel  in  WORD_ADDR_W  word address.
- bank_sel  in  BS_W=$clog2(NUM_BANKS)  bank index.
- byte_sel  in  YS_W=$clog2(BYTES_PER_WORD)  byte lane.
- write_en  in  1  write strobe, asynchronous GPIO level.
- read_en  in  1  read strobe, asynchronous GPIO level.
- trunc_sel  in  4  number of read-data LSBs forced to 0.
- busy  out  1  FSM not idle.
- data_valid  out  1  one-cycle pulse when data_out updates.
- cmd_drop  out  1  sticky: a command was discarded.
- sram_csb  out  NUM_BANKS  chip select per bank, active-low.
- sram_web  out  1  write enable, active-low, shared by all banks.
- sram_wmask  out  BYTES_PER_WORD  byte write mask, active-high.
- sram_addr  out  WORD_ADDR_W  shared address.
- sram_din  out  8*BYTES_PER_WORD  shared write data.
- sram_dout  in  NUM_BANKS*8*BYTES_PER_WORD  concatenated bank read data; bank 0 occupies the LSBs.

Behaviour:
- Reset values: data_out=0, data_valid=0, busy=0, cmd_drop=0, sram_csb=all 1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0. Reset asserted mid-operation aborts immediately; no macro access completes after rst rises.
- Strobes: write_en and read_en each pass through a SYNC_STAGES synchroniser. A command is the rising edge of the synchronised strobe, detected in IDLE only.
- Capture: on command detect, data_in, word_sel, bank_sel, byte_sel and trunc_sel are registered. Interface rule: these inputs must be stable at least SYNC_STAGES+1 cycles before the strobe rises and until data_valid or busy deasserts.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_CAP.
- IDLE→WR on a write edge.
  - WR lasts 1 cycle: sram_csb[bank]=0, web=0, wmask=onehot(byte_sel), din=data_in replicated on all lanes.
  - WR→IDLE.
- IDLE→RD_ISSUE on a read edge.
  - RD_ISSUE lasts 1 cycle: csb[bank]=0, web=1, wmask=0.
  - RD_ISSUE→RD_WAIT. RD_WAIT holds for RD_LATENCY-1 cycles; with RD_LATENCY=1 it lasts 0 cycles and goes straight to RD_CAP.
  - RD_CAP: data_out = selected lane of the bank word, with the low min(trunc_sel,8) bits cleared. data_valid=1 for that cycle, then →IDLE.
- Latency: a read edge detected in cycle T gives data_valid in cycle T+1+RD_LATENCY.
- data_out holds its value until the next RD_CAP. Writes never change data_out.
- busy=1 in every state except IDLE.
- Simultaneous write and read edges: the write executes, the read is discarded and cmd_drop is set.
- Any edge while busy: ignored, cmd_drop is set. The edge is not queued.
- bank_sel ≥ NUM_BANKS (non-power-of-2 configurations): no access is made, FSM stays IDLE, cmd_drop is set.
- cmd_drop clears only on rst.
- Outside WR/RD_ISSUE: all csb=1, web=1, wmask=0. The addr/din registers hold their last value.

Decomposition:
- Shared package impact_pkg:
  - FSM state enum.
  - Helper functions for BS_W and YS_W.
  - Constant MAX_TRUNC=8.
- One sub-module, impact_strobe_sync: synchroniser plus rising-edge detector, with SYNC_STAGES as its parameter. It is instantiated twice, once per strobe.
- The truncation/lane mux stays inline.

Test Plan:
- Reset: rst pulse asynchronous to clk → all outputs equal their reset values within the same cycle, with csb=4'b1111.
- Write then read back: write 0xA5 to bank 2, word 0x3FF, byte 1 → one cycle with csb=4'b1011, wmask=4'b0010, addr=0x3FF. Then read the same location with trunc_sel=0 → data_out=0xA5, data_valid exactly 1+RD_LATENCY cycles after the detect cycle.
- Truncation: stored 0xFF, read with trunc_sel=3 → data_out=0xF8. With trunc_sel=12 → data_out=0x00.
- Read latency sweep: RD_LATENCY=3, read edge detected at cycle T → data_valid at T+4 only, and busy high for cycles T+1..T+4.
- Collisions: write and read rise together → only the write occurs and cmd_drop=1. A second read edge while busy → no extra csb pulse.
- Reset mid-read: rst asserted during RD_WAIT → csb=all 1 immediately, no data_valid, data_out=0. A subsequent read works normally.

Source files
------------

// File: rtl/impact_pkg.sv
// Shared types and width helpers for the IMPACT SRAM controller.
package impact_pkg;

  localparam int MAX_TRUNC = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_CAP
  } state_e;

  // Select widths never collapse to zero bits, even for single-entry configurations.
  function automatic int bs_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int ys_w(input int bytes_per_word);
    return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
  endfunction

endpackage

// File: rtl/impact_strobe_sync.sv
// Synchronises an asynchronous GPIO strobe level and flags its rising edge.
module impact_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse on the first synchronised high sample.
  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/impact_sram_ctrl.sv
// Byte-serial GPIO command port driving NUM_BANKS SRAM macros.
// Handshake: a command is the synchronised rising edge of write_en/read_en seen in IDLE; busy marks the FSM away from IDLE and data_valid pulses for the single cycle data_out carries fresh read data.
module impact_sram_ctrl
  import impact_pkg::*;
#(
  parameter  int NUM_BANKS      = 4,
  parameter  int WORD_ADDR_W    = 10,
  parameter  int BYTES_PER_WORD = 4,
  parameter  int RD_LATENCY     = 1,
  parameter  int SYNC_STAGES    = 2,
  localparam int BS_W           = bs_w(NUM_BANKS),
  localparam int YS_W           = ys_w(BYTES_PER_WORD),
  localparam int WORD_W         = 8 * BYTES_PER_WORD
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      data_in,
  output logic [7:0]                      data_out,
  input  logic [WORD_ADDR_W-1:0]          word_sel,
  input  logic [BS_W-1:0]                 bank_sel,
  input  logic [YS_W-1:0]                 byte_sel,
  input  logic                            write_en,
  input  logic                            read_en,
  input  logic [3:0]                      trunc_sel,
  output logic                            busy,
  output logic                            data_valid,
  output logic                            cmd_drop,
  output logic [NUM_BANKS-1:0]            sram_csb,
  output logic                            sram_web,
  output logic [BYTES_PER_WORD-1:0]       sram_wmask,
  output logic [WORD_ADDR_W-1:0]          sram_addr,
  output logic [WORD_W-1:0]               sram_din,
  input  logic [NUM_BANKS*WORD_W-1:0]     sram_dout
);

  state_e          state_q, state_d;
  logic [2:0]      wait_cnt_q, wait_cnt_d;
  logic            wr_rise, rd_rise;
  logic            idle, bank_ok, wr_go, rd_go, drop_evt;
  logic [BS_W-1:0] bank_q;
  logic [YS_W-1:0] byte_q;
  logic [3:0]      trunc_q, trunc_eff;
  logic [7:0]      data_q, lane, keep_mask, rd_byte;
  logic [WORD_W-1:0] bank_word;

  impact_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk    (clk),
    .rst    (rst),
    .strobe (write_en),
    .rise   (wr_rise)
  );

  impact_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk    (clk),
    .rst    (rst),
    .strobe (read_en),
    .rise   (rd_rise)
  );

  // A write wins a simultaneous read; anything not accepted is recorded as dropped.
  assign idle     = (state_q == IDLE);
  assign bank_ok  = (int'(bank_sel) < NUM_BANKS);
  assign wr_go    = idle && wr_rise && bank_ok;
  assign rd_go    = idle && rd_rise && !wr_rise && bank_ok;
  assign drop_evt = (!idle && (wr_rise || rd_rise)) ||
                    (idle && wr_rise && rd_rise) ||
                    (idle && (wr_rise || rd_rise) && !bank_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_go) begin
          state_d = WR;
        end else if (rd_go) begin
          state_d = RD_ISSUE;
        end
      end
      WR: state_d = IDLE;
      RD_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = (RD_LATENCY == 1) ? RD_CAP : RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_cnt_q == 3'(RD_LATENCY - 2)) begin
          state_d = RD_CAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      RD_CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_csb   = '1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    case (state_q)
      WR: begin
        sram_csb[bank_q]   = 1'b0;
        sram_web           = 1'b0;
        sram_wmask[byte_q] = 1'b1;
      end
      RD_ISSUE: sram_csb[bank_q] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q    <= '0;
      byte_q    <= '0;
      trunc_q   <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
      data_q    <= '0;
      cmd_drop  <= 1'b0;
    end else begin
      if (wr_go || rd_go) begin
        bank_q    <= bank_sel;
        byte_q    <= byte_sel;
        trunc_q   <= trunc_sel;
        sram_addr <= word_sel;
      end
      if (wr_go) begin
        sram_din <= {BYTES_PER_WORD{data_in}};
      end
      if (state_q == RD_CAP) begin
        data_q <= rd_byte;
      end
      if (drop_evt) begin
        cmd_drop <= 1'b1;
      end
    end
  end

  // Lane select and LSB truncation; shift counts above MAX_TRUNC clear the whole byte.
  always_comb begin
    bank_word = sram_dout[int'(bank_q)*WORD_W +: WORD_W];
    lane      = bank_word[int'(byte_q)*8 +: 8];
    trunc_eff = (trunc_q > 4'(MAX_TRUNC)) ? 4'(MAX_TRUNC) : trunc_q;
    keep_mask = 8'hFF << trunc_eff;
    rd_byte   = lane & keep_mask;
  end

  // The fresh byte is passed through during RD_CAP so it lines up with data_valid; the register then holds it.
  assign data_out   = (state_q == RD_CAP) ? rd_byte : data_q;
  assign data_valid = (state_q == RD_CAP);
  assign busy       = !idle;

endmodule

// File: tb/tb_impact_sram_ctrl.sv
// Directed bench: two controllers (RD_LATENCY 1 and 3) share stimulus, each with its own SRAM model.
module tb_impact_sram_ctrl;

  localparam int NB  = 4;
  localparam int AW  = 10;
  localparam int BPW = 4;
  localparam int SS  = 2;
  localparam int NI  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic [AW-1:0] word_sel = '0;
  logic [1:0] bank_sel = '0;
  logic [1:0] byte_sel = '0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic [3:0] trunc_sel = '0;

  logic [7:0]    data_out   [NI];
  logic          busy       [NI];
  logic          data_valid [NI];
  logic          cmd_drop   [NI];
  logic [NB-1:0] sram_csb   [NI];
  logic          sram_web   [NI];
  logic [BPW-1:0] sram_wmask [NI];
  logic [AW-1:0] sram_addr  [NI];
  logic [31:0]   sram_din   [NI];

  int n_tests = 0;
  int n_fail  = 0;

  int          busy_cnt [NI], busy_first [NI], dv_cnt [NI], dv_at [NI], csb_cnt [NI];
  logic [7:0]  dv_data [NI];
  logic [3:0]  csb_seen [NI], wmask_seen [NI];
  logic        web_seen [NI];
  logic [AW-1:0] addr_seen [NI];
  logic [31:0] din_seen [NI];
  logic [3:0]  snap_csb1;
  logic        snap_busy1, snap_dv1;
  logic [7:0]  snap_dout0, snap_dout1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0]  mem  [NB][1 << AW];
    logic [31:0]  pipe [NB][L];
    logic [NB*32-1:0] dout;

    impact_sram_ctrl #(
      .NUM_BANKS(NB), .WORD_ADDR_W(AW), .BYTES_PER_WORD(BPW),
      .RD_LATENCY(L), .SYNC_STAGES(SS)
    ) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out[g]),
      .word_sel(word_sel), .bank_sel(bank_sel), .byte_sel(byte_sel),
      .write_en(write_en), .read_en(read_en), .trunc_sel(trunc_sel),
      .busy(busy[g]), .data_valid(data_valid[g]), .cmd_drop(cmd_drop[g]),
      .sram_csb(sram_csb[g]), .sram_web(sram_web[g]), .sram_wmask(sram_wmask[g]),
      .sram_addr(sram_addr[g]), .sram_din(sram_din[g]), .sram_dout(dout)
    );

    // Synchronous macro: read data appears L cycles after the select cycle.
    always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
        if (!sram_csb[g][b]) begin
          if (!sram_web[g]) begin
            for (int y = 0; y < BPW; y++) begin
              if (sram_wmask[g][y]) mem[b][sram_addr[g]][8*y +: 8] <= sram_din[g][8*y +: 8];
            end
          end else begin
            pipe[b][0] <= mem[b][sram_addr[g]];
          end
        end
        for (int s = 1; s < L; s++) pipe[b][s] <= pipe[b][s-1];
      end
    end

    always_comb begin
      dout = '0;
      for (int b = 0; b < NB; b++) dout[b*32 +: 32] = pipe[b][L-1];
    end
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic [1:0] b, input logic [AW-1:0] w, input logic [1:0] y,
                         input logic [7:0] d, input logic [3:0] t);
    bank_sel  = b;
    word_sel  = w;
    byte_sel  = y;
    data_in   = d;
    trunc_sel = t;
  endtask

  // Raises the strobes after the setup window, then samples k=1..14 on the negedge after posedge k.
  task automatic run_cmd(input logic do_wr, input logic do_rd, input int retrig_at, input int rst_at);
    for (int i = 0; i < NI; i++) begin
      busy_cnt[i] = 0; busy_first[i] = 0; dv_cnt[i] = 0; dv_at[i] = 0; csb_cnt[i] = 0;
      dv_data[i] = 'x; csb_seen[i] = 'x; wmask_seen[i] = 'x; web_seen[i] = 'x;
      addr_seen[i] = 'x; din_seen[i] = 'x;
    end
    repeat (SS + 2) @(negedge clk);
    write_en = do_wr;
    read_en  = do_rd;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (busy[i]) begin
          if (busy_cnt[i] == 0) busy_first[i] = k;
          busy_cnt[i]++;
        end
        if (data_valid[i]) begin
          dv_cnt[i]++;
          dv_at[i]   = k;
          dv_data[i] = data_out[i];
        end
        if (sram_csb[i] != 4'hF) begin
          csb_cnt[i]++;
          csb_seen[i]   = sram_csb[i];
          wmask_seen[i] = sram_wmask[i];
          web_seen[i]   = sram_web[i];
          addr_seen[i]  = sram_addr[i];
          din_seen[i]   = sram_din[i];
        end
      end
      if (k == 2) begin
        write_en = 1'b0;
        read_en  = 1'b0;
      end
      if (k == retrig_at) read_en = 1'b1;
      if (k == retrig_at + 2) read_en = 1'b0;
      if (k == rst_at) begin
        #1 rst = 1'b1;
        #1;
        snap_csb1  = sram_csb[1];
        snap_busy1 = busy[1];
        snap_dv1   = data_valid[1];
        snap_dout0 = data_out[0];
        snap_dout1 = data_out[1];
        #1 rst = 1'b0;
      end
    end
  endtask

  task automatic do_write(input logic [1:0] b, input logic [AW-1:0] w, input logic [1:0] y,
                          input logic [7:0] d);
    set_cmd(b, w, y, d, 4'd0);
    run_cmd(1'b1, 1'b0, 0, 0);
  endtask

  task automatic do_read(input logic [1:0] b, input logic [AW-1:0] w, input logic [1:0] y,
                         input logic [3:0] t, input logic [7:0] exp, input string tag);
    set_cmd(b, w, y, 8'h00, t);
    run_cmd(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), 32'(dv_data[i]), 32'(exp));
      check($sformatf("%s_dv_cnt[%0d]", tag, i), dv_cnt[i], 1);
    end
  endtask

  initial begin
    // Asynchronous reset between clock edges.
    #3 rst = 1'b1;
    #1;
    check("rst_data_out", 32'(data_out[0]), 32'h0);
    check("rst_data_valid", 32'(data_valid[0]), 32'h0);
    check("rst_busy", 32'(busy[0]), 32'h0);
    check("rst_cmd_drop", 32'(cmd_drop[0]), 32'h0);
    check("rst_csb", 32'(sram_csb[0]), 32'hF);
    check("rst_csb_l3", 32'(sram_csb[1]), 32'hF);
    check("rst_web", 32'(sram_web[0]), 32'h1);
    check("rst_wmask", 32'(sram_wmask[0]), 32'h0);
    check("rst_addr", 32'(sram_addr[0]), 32'h0);
    check("rst_din", sram_din[0], 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write 0xA5 to bank 2, word 0x3FF, byte 1.
    do_write(2'd2, 10'h3FF, 2'd1, 8'hA5);
    check("wr_csb_cnt", csb_cnt[0], 1);
    check("wr_csb", 32'(csb_seen[0]), 32'hB);
    check("wr_web", 32'(web_seen[0]), 32'h0);
    check("wr_wmask", 32'(wmask_seen[0]), 32'h2);
    check("wr_addr", 32'(addr_seen[0]), 32'h3FF);
    check("wr_din", din_seen[0], 32'hA5A5_A5A5);
    check("wr_busy_cnt", busy_cnt[0], 1);
    check("wr_busy_first", busy_first[0], SS + 1);
    check("wr_dv_cnt", dv_cnt[0], 0);
    check("wr_data_out_hold", 32'(data_out[0]), 32'h0);

    // Read back with per-instance latency.
    set_cmd(2'd2, 10'h3FF, 2'd1, 8'h00, 4'd0);
    run_cmd(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rd_data[%0d]", i), 32'(dv_data[i]), 32'hA5);
      check($sformatf("rd_dv_cnt[%0d]", i), dv_cnt[i], 1);
      check($sformatf("rd_dv_at[%0d]", i), dv_at[i], SS + 1 + lat(i));
      check($sformatf("rd_busy_first[%0d]", i), busy_first[i], SS + 1);
      check($sformatf("rd_busy_cnt[%0d]", i), busy_cnt[i], 1 + lat(i));
      check($sformatf("rd_csb_cnt[%0d]", i), csb_cnt[i], 1);
      check($sformatf("rd_csb[%0d]", i), 32'(csb_seen[i]), 32'hB);
      check($sformatf("rd_web[%0d]", i), 32'(web_seen[i]), 32'h1);
      check($sformatf("rd_wmask[%0d]", i), 32'(wmask_seen[i]), 32'h0);
      check($sformatf("rd_drop[%0d]", i), 32'(cmd_drop[i]), 32'h0);
    end

    // Truncation and lane selection.
    do_write(2'd0, 10'd5, 2'd3, 8'hFF);
    check("wr_keeps_data_out", 32'(data_out[0]), 32'hA5);
    do_write(2'd0, 10'd5, 2'd0, 8'h3C);
    do_read(2'd0, 10'd5, 2'd3, 4'd3,  8'hF8, "trunc3");
    do_read(2'd0, 10'd5, 2'd3, 4'd12, 8'h00, "trunc12");
    do_read(2'd0, 10'd5, 2'd3, 4'd7,  8'h80, "trunc7");
    do_read(2'd0, 10'd5, 2'd0, 4'd4,  8'h30, "lane0_trunc4");
    do_read(2'd0, 10'd5, 2'd0, 4'd0,  8'h3C, "lane0_trunc0");

    // Second read edge arrives while the latency-3 controller is still busy.
    set_cmd(2'd2, 10'h3FF, 2'd1, 8'h00, 4'd0);
    run_cmd(1'b0, 1'b1, 3, 0);
    check("busy_edge_csb_cnt_l3", csb_cnt[1], 1);
    check("busy_edge_dv_cnt_l3", dv_cnt[1], 1);
    check("busy_edge_drop_l3", 32'(cmd_drop[1]), 32'h1);
    check("busy_edge_csb_cnt_l1", csb_cnt[0], 2);
    check("busy_edge_dv_cnt_l1", dv_cnt[0], 2);
    check("busy_edge_drop_l1", 32'(cmd_drop[0]), 32'h0);

    // Reset while the latency-3 controller sits in RD_WAIT.
    run_cmd(1'b0, 1'b1, 0, SS + 2);
    check("midrst_csb_l3", 32'(snap_csb1), 32'hF);
    check("midrst_busy_l3", 32'(snap_busy1), 32'h0);
    check("midrst_dv_l3", 32'(snap_dv1), 32'h0);
    check("midrst_dout_l3", 32'(snap_dout1), 32'h0);
    check("midrst_dout_l1", 32'(snap_dout0), 32'h0);
    check("midrst_dv_cnt_l3", dv_cnt[1], 0);
    check("midrst_drop_l3", 32'(cmd_drop[1]), 32'h0);
    do_read(2'd2, 10'h3FF, 2'd1, 4'd0, 8'hA5, "post_rst_rd");

    // Write and read edges together: only the write happens.
    set_cmd(2'd1, 10'd7, 2'd0, 8'h5A, 4'd0);
    run_cmd(1'b1, 1'b1, 0, 0);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("coll_csb_cnt[%0d]", i), csb_cnt[i], 1);
      check($sformatf("coll_csb[%0d]", i), 32'(csb_seen[i]), 32'hD);
      check($sformatf("coll_web[%0d]", i), 32'(web_seen[i]), 32'h0);
      check($sformatf("coll_dv_cnt[%0d]", i), dv_cnt[i], 0);
      check($sformatf("coll_drop[%0d]", i), 32'(cmd_drop[i]), 32'h1);
    end
    do_read(2'd1, 10'd7, 2'd0, 4'd0, 8'h5A, "coll_readback");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
